// File: rtl/alu_seq.sv
// Sequencer that feeds an external ALU from a 4x8 register file and returns results
// through a valid/ready response port. ALU_LAT sets the external ALU's pipeline depth.
module alu_seq #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic       ck,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_ld,
    input  logic [3:0] cmd_op,
    input  logic [1:0] cmd_rd,
    input  logic [1:0] cmd_ra,
    input  logic [1:0] cmd_rb,
    input  logic       cmd_imm_en,
    input  logic [7:0] cmd_imm,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_ctr,
    input  logic [7:0] alu_o,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [1:0] rsp_rd,
    output logic       busy
);

    localparam int unsigned CntW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [7:0]        rf_q [4];
    logic [7:0]        rf_d [4];
    logic [7:0]        alu_a_q, alu_a_d;
    logic [7:0]        alu_b_q, alu_b_d;
    logic [3:0]        alu_ctr_q, alu_ctr_d;
    logic [1:0]        rd_q, rd_d;
    logic [7:0]        rsp_data_q, rsp_data_d;
    logic [1:0]        rsp_rd_q, rsp_rd_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rf_d       = rf_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_ctr_d  = alu_ctr_q;
        rd_d       = rd_q;
        rsp_data_d = rsp_data_q;
        rsp_rd_d   = rsp_rd_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    if (cmd_ld) begin
                        rf_d[cmd_rd] = cmd_imm;
                        rsp_data_d   = cmd_imm;
                        rsp_rd_d     = cmd_rd;
                        state_d      = StResp;
                    end else begin
                        // Operands are read here, so rd==ra/rb sees the pre-write value.
                        alu_a_d   = rf_q[cmd_ra];
                        alu_b_d   = cmd_imm_en ? cmd_imm : rf_q[cmd_rb];
                        alu_ctr_d = cmd_op;
                        rd_d      = cmd_rd;
                        cnt_d     = CntW'(ALU_LAT);
                        state_d   = StIssue;
                    end
                end
            end
            StIssue, StWait: begin
                if (cnt_q == '0) begin
                    rf_d[rd_q] = alu_o;
                    rsp_data_d = alu_o;
                    rsp_rd_d   = rd_q;
                    state_d    = StResp;
                end else begin
                    cnt_d   = cnt_q - CntW'(1);
                    state_d = StWait;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rf_q       <= '{default: '0};
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_ctr_q  <= '0;
            rd_q       <= '0;
            rsp_data_q <= '0;
            rsp_rd_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rf_q       <= rf_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_ctr_q  <= alu_ctr_d;
            rd_q       <= rd_d;
            rsp_data_q <= rsp_data_d;
            rsp_rd_q   <= rsp_rd_d;
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_data  = rsp_data_q;
    assign rsp_rd    = rsp_rd_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_ctr   = alu_ctr_q;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter ALU_LAT, default 1, meaning the number of ck cycles from operands stable at alu_a/alu_b/alu_ctr to a valid alu_o (0 = combinational ALU).
REQ-002 SHALL have port ck  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  command present.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when valid and ready are both high at an edge.
REQ-006 SHALL have port cmd_ld  input  1  load cmd_imm into rf[cmd_rd], bypassing the ALU.
REQ-007 SHALL have port cmd_op  input  4  ALU control code, forwarded unmodified to alu_ctr.
REQ-008 SHALL have port cmd_rd / cmd_ra / cmd_rb  input  2 each  destination / A-source / B-source register index.
REQ-009 SHALL have port cmd_imm_en  input  1  select cmd_imm instead of rf[cmd_rb] as operand B.
REQ-010 SHALL have port cmd_imm  input  8  immediate operand.
REQ-011 SHALL have port alu_a / alu_b  output  8 each  ALU operands.
REQ-012 SHALL have port alu_ctr  output  4  ALU control.
REQ-013 SHALL have port alu_o  input  8  ALU result.
REQ-014 SHALL have port rsp_valid  output  1  result available.
REQ-015 SHALL have port rsp_ready  input  1  result consumed when valid and ready are both high at an edge.
REQ-016 SHALL have port rsp_data  output  8  result value.
REQ-017 SHALL have port rsp_rd  output  2  register written.
REQ-018 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-019 SHALL contain a 4x8 register file rf; read at command accept, written only at result capture.
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; cmd_ready=1 only in IDLE.
REQ-021 IDLE: on accept with cmd_ld=1, capture rsp_data=cmd_imm, write rf[cmd_rd]=cmd_imm, go to RESP; with cmd_ld=0, latch rf[ra], (imm_en ? imm : rf[rb]), op and rd, go to ISSUE.
REQ-022 ISSUE/WAIT: alu_a, alu_b, alu_ctr SHALL hold the latched values constant from the first ISSUE cycle until leaving WAIT; in IDLE/RESP they SHALL hold their last values.
REQ-023 alu_o SHALL be sampled at the edge ending the (ALU_LAT+1)-th cycle after ISSUE entry (ALU_LAT=0: end of the ISSUE cycle, no WAIT cycles); at the same edge rf[rd] and rsp_data are written and state becomes RESP.
REQ-024 WAIT SHALL use a down-counter wide enough for ALU_LAT, loaded on ISSUE entry.
REQ-025 Command-to-rsp_valid latency SHALL be ALU_LAT+1 cycles after the accept edge for ALU ops, and 0 extra cycles (rsp_valid the cycle after accept) for loads.
REQ-026 RESP: rsp_valid=1; rsp_data and rsp_rd SHALL stay stable until rsp_ready; on handshake go to IDLE (next accept possible one cycle later, throughput = one command per ALU_LAT+3 cycles).
REQ-027 rd equal to ra or rb SHALL read the old value; the written value SHALL be visible to the next command.
REQ-028 cmd_* inputs SHALL be ignored outside IDLE; rsp_ready SHALL be ignored outside RESP.
REQ-029 Arithmetic SHALL be the ALU's; alu_o SHALL be stored as 8 bits, no extension or flags.

Reset
REQ-030 With rst_n=0 at an edge: state=IDLE, rf all 0x00, alu_a=alu_b=0x00, alu_ctr=0000, rsp_valid=0, rsp_data=0x00, rsp_rd=0, busy=0, counter=0; cmd_ready=1 from the first cycle after reset release.
REQ-031 Reset asserted in ISSUE/WAIT/RESP SHALL abort the command with no rf write and no response.

Verification (bench ALU model: registered, ALU_LAT=1, 0000 add, 0001 subtract)
REQ-032 Load 11 into r0, load 2 into r1, op 0000 rd=r2 ra=r0 rb=r1 -> rsp_data=13, rsp_rd=2, rsp_valid exactly 2 cycles after accept.
REQ-033 op 0001 ra=r0, imm_en=1, imm=0x0C -> rsp_data=0xFF (wrap-around); rf[rd]=0xFF.
REQ-034 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_data/rsp_rd stable, cmd_ready=0, new cmd_valid ignored.
REQ-035 op 0000 with rd=ra=r0 (r0=11, imm 2), then op 0000 ra=r0 imm 0 -> first result 13, second result 13.
REQ-036 rst_n=0 during WAIT -> no response, rf[rd] unchanged (reads 0x00 after reset), busy=0 next cycle.
REQ-037 Rerun REQ-032 with ALU_LAT=0 and a combinational model -> rsp_valid 1 cycle after accept, same data.
